// File: rtl/int_ctrl.sv
// int_ctrl: synchronises/latches device IRQs, masks and fixed-priority arbitrates them onto CP0 Int via req/ack/eoi.
// irq_in -> int_out in 3 clocks (+2 with INT_CTRL_GLITCH_FILTER_EN); no backpressure, one interrupt in flight at a time.
module int_ctrl #(
    parameter int NUM_IRQ     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic               int_ack,
    input  logic               eoi,
    output logic [NUM_IRQ-1:0] int_out,
    output logic [2:0]         int_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_MASK    = 2'd0;
    localparam logic [1:0] A_MODE    = 2'd1;
    localparam logic [1:0] A_PENDING = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] raw;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] s_hist;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] wdat;
    logic [NUM_IRQ-1:0] mask_nxt;
    logic [NUM_IRQ-1:0] mode_nxt;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] id_onehot;
    logic [NUM_IRQ-1:0] winner_onehot;
    logic [NUM_IRQ-1:0] int_out_nxt;
    logic [2:0]         winner;
    logic [2:0]         int_id_nxt;
    logic               busy_nxt;
    logic               unused_wr_bits;

    assign wdat           = wr_data[NUM_IRQ-1:0];
    assign unused_wr_bits = ^wr_data[31:NUM_IRQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

`ifdef INT_CTRL_GLITCH_FILTER_EN
    logic [NUM_IRQ-1:0] raw_d;
    logic [NUM_IRQ-1:0] filt_q;

    // A bit only moves once the synchroniser output agrees with its previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_d  <= '0;
            filt_q <= '0;
        end else begin
            raw_d  <= raw;
            filt_q <= (~(raw ^ raw_d) & raw) | ((raw ^ raw_d) & filt_q);
        end
    end

    assign s = filt_q;
`else
    assign s = raw;
`endif

    always_comb begin
        mask_nxt = mask;
        mode_nxt = mode;
        w1c      = '0;
        if (wr_en) begin
            case (wr_addr)
                A_MASK:    mask_nxt = wdat;
                A_MODE:    mode_nxt = wdat;
                A_PENDING: w1c      = wdat;
                default:   ;
            endcase
        end
    end

    assign id_onehot = NUM_IRQ'(1) << int_id;
    assign ack_clr   = (state == REQ && int_ack) ? id_onehot : '0;
    assign rise      = s & ~s_hist;
    // Rising edge beats any clear landing in the same cycle.
    assign edge_pend = rise | (pending & ~((w1c | ack_clr) & mode));
    // Bits that are (or are becoming) level track the synchronised line directly.
    assign pending_nxt = (mode_nxt & edge_pend) | (~mode_nxt & s);
    assign eligible    = pending & mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_hist  <= '0;
            mask    <= '0;
            mode    <= '0;
            pending <= '0;
        end else begin
            s_hist  <= s;
            mask    <= mask_nxt;
            mode    <= mode_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        winner = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    assign winner_onehot = NUM_IRQ'(1) << winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            int_out <= '0;
            int_id  <= 3'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            int_out <= int_out_nxt;
            int_id  <= int_id_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        int_out_nxt = int_out;
        int_id_nxt  = int_id;
        busy_nxt    = busy;
        case (state)
            IDLE: begin
                int_out_nxt = '0;
                busy_nxt    = 1'b0;
                if (|eligible) begin
                    int_id_nxt  = winner;
                    int_out_nxt = winner_onehot;
                    busy_nxt    = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    int_out_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SERVICE;
                end else if (!eligible[int_id]) begin
                    int_out_nxt = '0;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            SERVICE: begin
                int_out_nxt = '0;
                busy_nxt    = 1'b1;
                if (eoi) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                int_out_nxt = '0;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            A_MASK:    rd_data[NUM_IRQ-1:0] = mask;
            A_MODE:    rd_data[NUM_IRQ-1:0] = mode;
            A_PENDING: rd_data[NUM_IRQ-1:0] = pending;
            A_STATUS:  rd_data[5:0]         = {state, busy, int_id};
            default:   rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: handshake, priority, withdrawal, edge/level latching, W1C and reset.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  irq_in;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        int_ack;
    logic        eoi;
    logic [4:0]  int_out;
    logic [2:0]  int_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int_ctrl #(.NUM_IRQ(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .int_ack(int_ack), .eoi(eoi),
        .int_out(int_out), .int_id(int_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0; wr_data = 32'd0;
    endtask

    task automatic do_reset();
        irq_in = '0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_addr = 0; int_ack = 0; eoi = 0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (int_out !== 5'b0) begin bad++; $display("FAIL rst_int_out got=%b exp=%b", int_out, 5'b0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (int_id !== 3'd0) begin bad++; $display("FAIL rst_int_id got=%0d exp=0", int_id); end
        rd_addr = 2'd3; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", rd_data); end
    endtask

    task automatic test_level();
        do_reset();
        wr(2'd0, 32'h1F);
        wr(2'd1, 32'h00);
        irq_in = 5'b00100;
        tick(3);
        total++; if (int_out !== 5'b0) begin bad++; $display("FAIL lvl_early got=%b exp=%b", int_out, 5'b0); end
        tick(1);
        total++; if (int_out !== 5'b00100) begin bad++; $display("FAIL lvl_int_out got=%b exp=%b", int_out, 5'b00100); end
        total++; if (int_id !== 3'd2) begin bad++; $display("FAIL lvl_int_id got=%0d exp=2", int_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL lvl_busy got=%b exp=1", busy); end
        rd_addr = 2'd3; #1;
        total++; if (rd_data !== 32'h1A) begin bad++; $display("FAIL lvl_status_req got=%h exp=1a", rd_data); end
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        total++; if (int_out !== 5'b0) begin bad++; $display("FAIL lvl_ack_out got=%b exp=%b", int_out, 5'b0); end
        rd_addr = 2'd3; #1;
        total++; if (rd_data !== 32'h2A) begin bad++; $display("FAIL lvl_status_svc got=%h exp=2a", rd_data); end
        eoi = 1'b1; tick(1); eoi = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lvl_eoi_busy got=%b exp=0", busy); end
        tick(1);
        total++; if (int_out !== 5'b00100) begin bad++; $display("FAIL lvl_rereq got=%b exp=%b", int_out, 5'b00100); end
    endtask

    task automatic test_edge_priority();
        do_reset();
        wr(2'd0, 32'h1F);
        wr(2'd1, 32'h1F);
        irq_in = 5'b10000; tick(1); irq_in = 5'b0;
        tick(3);
        total++; if (int_id !== 3'd4 || int_out !== 5'b10000) begin bad++; $display("FAIL edg_first got id=%0d out=%b exp id=4 out=10000", int_id, int_out); end
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        irq_in = 5'b01000; tick(1);
        irq_in = 5'b00010; tick(1);
        irq_in = 5'b0; tick(3);
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h0A) begin bad++; $display("FAIL edg_pend_svc got=%h exp=0a", rd_data); end
        total++; if (int_out !== 5'b0 || busy !== 1'b1) begin bad++; $display("FAIL edg_svc_hold got out=%b busy=%b exp out=00000 busy=1", int_out, busy); end
        eoi = 1'b1; tick(1); eoi = 1'b0;
        tick(1);
        total++; if (int_id !== 3'd1 || int_out !== 5'b00010) begin bad++; $display("FAIL edg_second got id=%0d out=%b exp id=1 out=00010", int_id, int_out); end
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h08) begin bad++; $display("FAIL edg_ack_clr got=%h exp=08", rd_data); end
        eoi = 1'b1; tick(1); eoi = 1'b0;
        tick(1);
        total++; if (int_id !== 3'd3 || int_out !== 5'b01000) begin bad++; $display("FAIL edg_third got id=%0d out=%b exp id=3 out=01000", int_id, int_out); end
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        eoi = 1'b1; tick(1); eoi = 1'b0;
        tick(1);
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL edg_pend_end got=%h exp=0", rd_data); end
        total++; if (busy !== 1'b0 || int_out !== 5'b0) begin bad++; $display("FAIL edg_idle_end got busy=%b out=%b exp busy=0 out=00000", busy, int_out); end
    endtask

    task automatic test_withdraw();
        do_reset();
        wr(2'd0, 32'h1F);
        irq_in = 5'b00001;
        tick(4);
        total++; if (int_out !== 5'b00001 || busy !== 1'b1) begin bad++; $display("FAIL wd_req got out=%b busy=%b exp out=00001 busy=1", int_out, busy); end
        wr(2'd0, 32'h1E);
        total++; if (int_out !== 5'b00001) begin bad++; $display("FAIL wd_hold got=%b exp=%b", int_out, 5'b00001); end
        tick(1);
        total++; if (int_out !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL wd_out got out=%b busy=%b exp out=00000 busy=0", int_out, busy); end
        rd_addr = 2'd3; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL wd_status got=%h exp=0", rd_data); end
    endtask

    task automatic test_ack_edge_collision();
        do_reset();
        wr(2'd0, 32'h1F);
        wr(2'd1, 32'h1F);
        irq_in = 5'b00100; tick(1);
        irq_in = 5'b0;     tick(1);
        irq_in = 5'b00100; tick(1);
        irq_in = 5'b0;     tick(1);
        total++; if (int_out !== 5'b00100) begin bad++; $display("FAIL col_req got=%b exp=%b", int_out, 5'b00100); end
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h04) begin bad++; $display("FAIL col_pend got=%h exp=04", rd_data); end
        eoi = 1'b1; tick(1); eoi = 1'b0;
        tick(1);
        total++; if (int_out !== 5'b00100 || int_id !== 3'd2) begin bad++; $display("FAIL col_rereq got out=%b id=%0d exp out=00100 id=2", int_out, int_id); end
    endtask

    task automatic test_w1c();
        do_reset();
        wr(2'd1, 32'h1E);
        irq_in = 5'b01011; tick(1);
        irq_in = 5'b00001; tick(3);
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h0B) begin bad++; $display("FAIL w1c_before got=%h exp=0b", rd_data); end
        wr(2'd2, 32'h03);
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h09) begin bad++; $display("FAIL w1c_after got=%h exp=09", rd_data); end
        wr(2'd1, 32'h16);
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h01) begin bad++; $display("FAIL w1c_mode_switch got=%h exp=01", rd_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL w1c_masked_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_in_service();
        do_reset();
        wr(2'd0, 32'h1F);
        wr(2'd1, 32'h1F);
        irq_in = 5'b01001; tick(1); irq_in = 5'b0;
        tick(3);
        total++; if (int_id !== 3'd0 || int_out !== 5'b00001) begin bad++; $display("FAIL rs_req got id=%0d out=%b exp id=0 out=00001", int_id, int_out); end
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        rd_addr = 2'd3; #1;
        total++; if (rd_data !== 32'h28) begin bad++; $display("FAIL rs_svc got=%h exp=28", rd_data); end
        rst = 1'b1; tick(1); rst = 1'b0;
        total++; if (int_out !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL rs_out got out=%b busy=%b exp out=00000 busy=0", int_out, busy); end
        rd_addr = 2'd0; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rs_mask got=%h exp=0", rd_data); end
        rd_addr = 2'd1; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rs_mode got=%h exp=0", rd_data); end
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rs_pending got=%h exp=0", rd_data); end
        eoi = 1'b1; int_ack = 1'b1; tick(1); eoi = 1'b0; int_ack = 1'b0;
        tick(1);
        rd_addr = 2'd3; #1;
        total++; if (rd_data !== 32'h0 || int_out !== 5'b0) begin bad++; $display("FAIL rs_stray got status=%h out=%b exp status=0 out=00000", rd_data, int_out); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_priority();
        test_withdraw();
        test_ack_edge_collision();
        test_w1c();
        test_reset_in_service();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt source controller that produces the five hardware interrupt lines (Int[4:0]) consumed by CP0.
- Synchronises raw device IRQs and latches them as level or edge events.
- Masks, prioritises and presents one interrupt at a time to the CPU with a request/acknowledge/end-of-interrupt handshake.
- Exposes a small register file so software can program masks and modes, and clear pending events.

Parameters:
NUM_IRQ, 5, number of device IRQ inputs; equals CP0 Int width; max 8.
SYNC_STAGES, 2, flip-flop stages in each irq_in synchroniser; min 2.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  reset; synchronous, active-high.
irq_in  input  NUM_IRQ  asynchronous device interrupt lines; active-high.
wr_en  input  1  register write strobe; one-cycle pulse.
wr_addr  input  2  register select for write.
wr_data  input  32  write data; bits [NUM_IRQ-1:0] used.
rd_addr  input  2  register select for read.
rd_data  output  32  combinational read data; unused bits 0.
int_ack  input  1  CPU accepted the presented interrupt (CP0 exception entry); one-cycle pulse.
eoi  input  1  end of interrupt (ERET); one-cycle pulse.
int_out  output  NUM_IRQ  one-hot request to CP0 Int; registered.
int_id  output  3  index of the interrupt currently requested or in service; registered.
busy  output  1  high in REQ or SERVICE; registered.

Behaviour:
Reset:
- Clears all of the following to 0: synchronisers, edge-history flops, MASK, MODE, PENDING, int_out, int_id, busy. State returns to IDLE.
- Reset during REQ or SERVICE abandons the interrupt; no ack is required.

Register map:
- 0 MASK: RW; 1 = enabled.
- 1 MODE: RW; 1 = edge, 0 = level.
- 2 PENDING: read returns raw pending bits; write-1-to-clear, edge bits only.
- 3 STATUS: RO; [2:0] = int_id, [3] = busy, [5:4] = state encoding.

Source latching:
- s[i] is irq_in[i] after SYNC_STAGES flops.
- Level source: PENDING[i] = s[i] each cycle.
- Edge source: PENDING[i] sets on the s[i] 0->1 transition, then holds until cleared by ack or a software W1C.
- Set and clear in the same cycle: set wins.
- Changing MODE from edge to level immediately replaces PENDING[i] with s[i].

Arbitration:
- eligible = PENDING & MASK.
- Lowest index has highest priority, evaluated only in IDLE.

State machine (IDLE, REQ, SERVICE):
- IDLE:
  - If eligible != 0, latch winner into int_id, drive int_out = one-hot(int_id), busy = 1, go to REQ on the next edge.
  - Otherwise int_out = 0.
- REQ:
  - Hold int_out stable.
  - If int_ack: go to SERVICE, clear int_out, clear PENDING[int_id] if edge mode.
  - Else if eligible[int_id] drops (masked, or level source deasserted): withdraw; int_out = 0, busy = 0, go to IDLE. No priority change mid-REQ.
  - int_ack and withdraw in the same cycle: ack wins.
- SERVICE:
  - int_out = 0; int_id held.
  - On eoi: go to IDLE, busy = 0.
  - int_ack while in SERVICE or IDLE is ignored.
  - eoi outside SERVICE is ignored.

Latency:
- irq_in first sampled high at edge E0 gives PENDING high after edge E(SYNC_STAGES).
- int_out asserts after edge E(SYNC_STAGES+1); with defaults, 3 clocks.
- Re-arbitration after eoi takes one cycle: IDLE is evaluated in the cycle after eoi.

Register writes:
- Take effect on the next edge.
- A write to MASK that disables the in-REQ source causes withdrawal the following cycle.

Optional Feature:
Macro INT_CTRL_GLITCH_FILTER_EN.
- Defined: s[i] changes only after the synchroniser output has held the new value for 2 consecutive cycles. This rejects 1-cycle pulses and adds 2 cycles to the level-source latency.
- Undefined: s[i] is the raw synchroniser output and latency is as stated above.
- Register map and handshake are identical in both builds.

Test Plan:
1. Reset, then MASK=0x1F, MODE=0, hold irq_in=5'b00100 -> int_out=5'b00100 exactly 3 cycles after first sample, int_id=2, busy=1. int_ack -> int_out=0. eoi -> busy=0. irq still high -> re-request in 1 cycle.
2. MODE=0x1F, MASK=0x1F, single-cycle pulses on irq 3 then irq 1 while in SERVICE of irq 4 -> after eoi, int_id=1 first. After its ack and eoi, int_id=3. PENDING reads 0 at the end.
3. REQ for irq 0 (level), then write MASK=0x1E before int_ack -> withdrawal next cycle: int_out=0, busy=0, state IDLE.
4. Edge source with a new rising edge on the same cycle as int_ack -> PENDING[i] stays 1. After eoi, the same id is requested again.
5. Software W1C: PENDING=0x0A (edge), write reg 2 = 0x02 -> PENDING=0x08. Write to a level bit has no effect.
6. Assert rst during SERVICE -> next cycle int_out=0, busy=0, MASK=0, MODE=0, PENDING=0. A stray eoi is ignored.
